// File: rtl/acc_reg.sv
// acc_reg: WIDTH-bit accumulator register for the ALU datapath.
// Supports synchronous clear, parallel load, single-step left/right shifts
// (arithmetic or serial-fill on the right), and an autonomous multi-step
// shift sequencer with a busy/done handshake. The register drives the shared
// bus only while oe is high.
module acc_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] sum,
    input  logic             shr,
    input  logic             shl,
    input  logic             arith,
    input  logic             sin,
    input  logic             start,
    input  logic             dir,
    input  logic [CW-1:0]    cnt,
    input  logic             oe,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] obus,
    output logic             lsb_out,
    output logic             msb_out,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             neg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_rem;
    logic             r_dir;
    logic [WIDTH-1:0] r_a;
    logic             r_lsb;
    logic             r_msb;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_shr_val;
    logic [WIDTH-1:0] w_shl_val;
    logic             w_fill;
    logic             w_last_step;

    // One right-shift step: fill bit is taken from the live register msb
    // or the serial input.
    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] v,
                                                     input logic             fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    // One left-shift step: serial input enters at the lsb.
    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] v,
                                                    input logic             fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    // Shift candidates and sequencer terminal-count decode.
    always_comb begin
        w_fill      = 1'b0;
        w_shr_val   = '0;
        w_shl_val   = '0;
        w_last_step = 1'b0;
        if (arith) begin
            w_fill = r_a[WIDTH-1];
        end else begin
            w_fill = sin;
        end
        w_shr_val   = shift_right(r_a, w_fill);
        w_shl_val   = shift_left(r_a, sin);
        w_last_step = (r_rem == {{(CW-1){1'b0}}, 1'b1});
    end

    // Register, shifted-out bits and sequencer state; done is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= {CW{1'b0}};
            r_dir   <= 1'b0;
            r_a     <= {WIDTH{1'b0}};
            r_lsb   <= 1'b0;
            r_msb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_a <= {WIDTH{1'b0}};
                    end else if (start) begin
                        if (cnt == {CW{1'b0}}) begin
                            // Zero-length sequence completes immediately.
                            r_done <= 1'b1;
                        end else begin
                            r_rem   <= cnt;
                            r_dir   <= dir;
                            r_busy  <= 1'b1;
                            r_state <= S_BUSY;
                        end
                    end else if (ld) begin
                        r_a <= sum;
                    end else if (shr) begin
                        r_a   <= w_shr_val;
                        r_lsb <= r_a[0];
                    end else if (shl) begin
                        r_a   <= w_shl_val;
                        r_msb <= r_a[WIDTH-1];
                    end else begin
                        r_a <= r_a;
                    end
                end
                S_BUSY: begin
                    if (clr) begin
                        // Abort: no done pulse.
                        r_a     <= {WIDTH{1'b0}};
                        r_rem   <= {CW{1'b0}};
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_dir) begin
                            r_a   <= w_shl_val;
                            r_msb <= r_a[WIDTH-1];
                        end else begin
                            r_a   <= w_shr_val;
                            r_lsb <= r_a[0];
                        end
                        r_rem <= r_rem - {{(CW-1){1'b0}}, 1'b1};
                        if (w_last_step) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_busy <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rem   <= {CW{1'b0}};
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a       = r_a;
    assign lsb_out = r_lsb;
    assign msb_out = r_msb;
    assign busy    = r_busy;
    assign done    = r_done;
    assign zero    = (r_a == {WIDTH{1'b0}});
    assign neg     = r_a[WIDTH-1];
    assign obus    = oe ? r_a : {WIDTH{1'bz}};

endmodule

// File: tb/tb_acc_reg.sv
// Self-checking bench for acc_reg: directed steps from the test plan followed
// by randomized single-step and multi-step traffic against a reference model.
module tb_acc_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          ld;
    logic [W-1:0]  sum;
    logic          shr;
    logic          shl;
    logic          arith;
    logic          sin;
    logic          start;
    logic          dir;
    logic [CW-1:0] cnt;
    logic          oe;
    wire  [W-1:0]  a;
    wire  [W-1:0]  obus;
    wire           lsb_out;
    wire           msb_out;
    wire           busy;
    wire           done;
    wire           zero;
    wire           neg;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    logic [W-1:0] m_a;
    logic         m_lsb;
    logic         m_msb;

    acc_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .sum(sum), .shr(shr),
        .shl(shl), .arith(arith), .sin(sin), .start(start), .dir(dir),
        .cnt(cnt), .oe(oe), .a(a), .obus(obus), .lsb_out(lsb_out),
        .msb_out(msb_out), .busy(busy), .done(done), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    // Right shift by arithmetic: signed divide-by-two or unsigned halve plus fill weight.
    function automatic logic [W-1:0] ref_shr(input logic [W-1:0] v, input logic ar,
                                             input logic s);
        int t;
        if (ar) begin
            t = int'($signed(v)) >>> 1;
        end else begin
            t = int'(v) / 2 + (s ? (1 << (W - 1)) : 0);
        end
        return t[W-1:0];
    endfunction

    // Left shift by arithmetic: double plus serial bit, modulo 2**W.
    function automatic logic [W-1:0] ref_shl(input logic [W-1:0] v, input logic s);
        int t;
        t = int'(v) * 2 + int'(s);
        return t[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ":a"},    a, m_a);
        chk({tag, ":lsb"},  {7'd0, lsb_out}, {7'd0, m_lsb});
        chk({tag, ":msb"},  {7'd0, msb_out}, {7'd0, m_msb});
        chk({tag, ":zero"}, {7'd0, zero}, {7'd0, (m_a == 8'd0)});
        chk({tag, ":neg"},  {7'd0, neg},  {7'd0, m_a[W-1]});
        if (oe) begin
            chk({tag, ":obus"}, obus, m_a);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        clr = 1'b0; ld = 1'b0; shr = 1'b0; shl = 1'b0; start = 1'b0;
    endtask

    // Apply one IDLE-cycle command and predict its effect from the priority order.
    task automatic step_idle(input string tag);
        if (clr) begin
            m_a = 8'd0;
        end else if (ld) begin
            m_a = sum;
        end else if (shr) begin
            m_lsb = m_a[0];
            m_a   = ref_shr(m_a, arith, sin);
        end else if (shl) begin
            m_msb = m_a[W-1];
            m_a   = ref_shl(m_a, sin);
        end
        tick();
        chk_all(tag);
        chk({tag, ":busy"}, {7'd0, busy}, 8'd0);
        chk({tag, ":done"}, {7'd0, done}, 8'd0);
        quiet();
    endtask

    // Multi-step sequence of n shifts; optional random noise on ignored inputs.
    task automatic run_multi(input int n, input logic d, input bit rnd);
        quiet();
        start = 1'b1; dir = d; cnt = CW'(n);
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk_all("m0");
            chk("m0:busy", {7'd0, busy}, 8'd0);
            chk("m0:done", {7'd0, done}, 8'd1);
            tick();
            chk("m0:done_fall", {7'd0, done}, 8'd0);
            return;
        end
        chk_all("mk");
        chk("mk:busy", {7'd0, busy}, 8'd1);
        chk("mk:done", {7'd0, done}, 8'd0);
        for (int i = 1; i <= n; i++) begin
            if (rnd) begin
                arith = 1'($urandom); sin = 1'($urandom); ld = 1'($urandom);
                shr = 1'($urandom); shl = 1'($urandom); start = 1'($urandom);
                sum = 8'($urandom); cnt = CW'($urandom);
            end
            if (d) begin
                m_msb = m_a[W-1];
                m_a   = ref_shl(m_a, sin);
            end else begin
                m_lsb = m_a[0];
                m_a   = ref_shr(m_a, arith, sin);
            end
            tick();
            chk_all("mstep");
            chk("mstep:busy", {7'd0, busy}, {7'd0, (i < n)});
            chk("mstep:done", {7'd0, done}, {7'd0, (i == n)});
        end
        quiet();
        tick();
        chk_all("mpost");
        chk("mpost:busy", {7'd0, busy}, 8'd0);
        chk("mpost:done", {7'd0, done}, 8'd0);
    endtask

    initial begin
        rst = 1'b1; quiet(); sum = 8'd0; arith = 1'b0; sin = 1'b0;
        dir = 1'b0; cnt = '0; oe = 1'b1;
        m_a = 8'd0; m_lsb = 1'b0; m_msb = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_all("reset");
        chk("reset:busy", {7'd0, busy}, 8'd0);
        chk("reset:done", {7'd0, done}, 8'd0);

        // Load and bus enable
        ld = 1'b1; sum = 8'hA5; step_idle("ld_a5");
        chk("ld_a5_const", a, 8'hA5);
        oe = 1'b0; #1;
        chk("obus_off", {7'd0, (obus !== 8'hA5)}, 8'd1);
        oe = 1'b1; #1;
        chk("obus_on", obus, 8'hA5);

        // Single-step right shifts from 0x96
        ld = 1'b1; sum = 8'h96; step_idle("ld_96");
        shr = 1'b1; arith = 1'b1; step_idle("shr_arith");
        chk("shr_arith_const", a, 8'hCB);
        chk("shr_arith_lsb", {7'd0, lsb_out}, 8'd0);
        shr = 1'b1; arith = 1'b0; sin = 1'b0; step_idle("shr_sin0");
        chk("shr_sin0_const", a, 8'h65);
        chk("shr_sin0_lsb", {7'd0, lsb_out}, 8'd1);

        // Single-step left shift from 0x81
        ld = 1'b1; sum = 8'h81; step_idle("ld_81");
        shl = 1'b1; sin = 1'b1; step_idle("shl");
        chk("shl_const", a, 8'h03);
        chk("shl_msb", {7'd0, msb_out}, 8'd1);

        // Multi-step arithmetic right shift of 0x80 by 3
        ld = 1'b1; sum = 8'h80; step_idle("ld_80");
        arith = 1'b1; sin = 1'b0;
        run_multi(3, 1'b0, 1'b0);
        chk("multi_final", a, 8'hF0);
        chk("multi_neg", {7'd0, neg}, 8'd1);

        // Zero-length sequence
        run_multi(0, 1'b0, 1'b0);
        chk("cnt0_a", a, 8'hF0);

        // Abort with clr at the 2nd busy cycle
        ld = 1'b1; sum = 8'h5A; step_idle("ld_5a");
        start = 1'b1; dir = 1'b1; cnt = CW'(5); sin = 1'b0;
        tick();
        start = 1'b0;
        m_msb = m_a[W-1]; m_a = ref_shl(m_a, sin);
        tick();
        chk_all("abort_pre");
        chk("abort_pre:busy", {7'd0, busy}, 8'd1);
        clr = 1'b1; m_a = 8'd0;
        tick();
        clr = 1'b0;
        chk_all("abort");
        chk("abort:busy", {7'd0, busy}, 8'd0);
        chk("abort:done", {7'd0, done}, 8'd0);
        tick();
        chk("abort:no_done", {7'd0, done}, 8'd0);

        // ld beats shr in IDLE
        ld = 1'b1; shr = 1'b1; sum = 8'h3C; step_idle("ld_vs_shr");
        chk("ld_vs_shr_const", a, 8'h3C);

        // start held during busy is ignored
        arith = 1'b0; sin = 1'b1;
        start = 1'b1; dir = 1'b0; cnt = CW'(2);
        tick();
        cnt = CW'(7);
        m_lsb = m_a[0]; m_a = ref_shr(m_a, arith, sin);
        tick();
        chk("ign_start:busy1", {7'd0, busy}, 8'd1);
        m_lsb = m_a[0]; m_a = ref_shr(m_a, arith, sin);
        tick();
        start = 1'b0;
        chk_all("ign_start");
        chk("ign_start:done", {7'd0, done}, 8'd1);
        chk("ign_start:const", a, 8'hCF);
        tick();
        chk("ign_start:idle", {7'd0, busy}, 8'd0);

        // Asynchronous reset mid-sequence
        start = 1'b1; dir = 1'b0; cnt = CW'(6);
        tick();
        start = 1'b0;
        m_lsb = m_a[0]; m_a = ref_shr(m_a, arith, sin);
        tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_a = 8'd0; m_lsb = 1'b0; m_msb = 1'b0;
        chk_all("async_rst");
        chk("async_rst:busy", {7'd0, busy}, 8'd0);
        chk("async_rst:done", {7'd0, done}, 8'd0);
        #2 rst = 1'b0;
        tick();
        chk("async_rst:no_done", {7'd0, done}, 8'd0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            arith = 1'($urandom); sin = 1'($urandom); oe = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_multi(int'($urandom_range(0, 15)), 1'($urandom), 1'b1);
            end else begin
                clr = ($urandom_range(0, 7) == 0);
                ld  = 1'($urandom); shr = 1'($urandom); shl = 1'($urandom);
                sum = 8'($urandom);
                step_idle("rand_idle");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
